// File: rtl/qkv_seq_ctrl.sv
// qkv_seq_ctrl: sequences token reads into the binary QKV engine per weight block, with prime slots,
// tagged result FIFO (4 deep, FWFT) and done pulse. Optional macro QKV_SEQ_PERF_EN adds perf_stall.
`default_nettype none

module qkv_seq_ctrl #(
  parameter int DW     = 16,
  parameter int AW     = 5,
  parameter int TOKENS = 30,
  parameter int BLOCKS = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          tok_rd_en,
  output logic [AW-1:0] tok_rd_addr,
  input  logic [DW-1:0] tok_rd_data,
  output logic [DW-1:0] qkv_data_in,
  output logic          qkv_in_valid,
  output logic [2:0]    qkv_blk_sel,
  input  logic [DW-1:0] qkv_q,
  input  logic [DW-1:0] qkv_k,
  input  logic [DW-1:0] qkv_v,
  input  logic          qkv_out_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_q,
  output logic [DW-1:0] out_k,
  output logic [DW-1:0] out_v,
  output logic [AW-1:0] out_tok,
  output logic [2:0]    out_blk
`ifdef QKV_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_stall
`endif
);

  localparam logic [AW:0] LAST_TOK = (AW+1)'(TOKENS - 1);
  localparam logic [2:0]  LAST_BLK = 3'(BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] k;
    logic [DW-1:0] v;
    logic [AW-1:0] tok;
    logic [2:0]    blk;
  } entry_t;

  state_t      state, state_nxt;
  logic [2:0]  blk, blk_nxt;
  logic [AW:0] tok_idx, tok_idx_nxt;
  logic [2:0]  blk_sel;

  // Pipeline slot tags: S2 = engine input cycle, S3 = engine result cycle.
  logic          s2_vld, s2_dis, s3_vld, s3_dis;
  logic [AW-1:0] s2_tok, s3_tok;
  logic [2:0]    s2_blk, s3_blk;

  entry_t     mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  logic       s2_real, s3_real;
  logic [1:0] inflight;
  logic [3:0] occupancy;
  logic       credit_ok, issue, prime_slot, push, pop;

  always_comb begin
    s2_real    = s2_vld && !s2_dis;
    s3_real    = s3_vld && !s3_dis;
    inflight   = 2'(s2_real) + 2'(s3_real);
    occupancy  = {1'b0, count} + {2'b00, inflight};
    credit_ok  = occupancy < 4'd4;
    issue      = (state == S_RUN) && credit_ok;
    prime_slot = (state == S_PRIME);
    push       = s3_real && qkv_out_valid;
    pop        = (count != 3'd0) && out_ready;
  end

  always_comb begin
    state_nxt   = state;
    blk_nxt     = blk;
    tok_idx_nxt = tok_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_PRIME;
          blk_nxt     = 3'd0;
          tok_idx_nxt = '0;
        end
      end
      S_PRIME: state_nxt = S_RUN;
      S_RUN: begin
        if (issue) begin
          if (tok_idx == LAST_TOK) begin
            tok_idx_nxt = '0;
            if (blk == LAST_BLK) begin
              state_nxt = S_DRAIN;
            end else begin
              state_nxt = S_PRIME;
              blk_nxt   = blk + 3'd1;
            end
          end else begin
            tok_idx_nxt = tok_idx + {{AW{1'b0}}, 1'b1};
          end
        end
      end
      S_DRAIN: begin
        if (inflight == 2'd0 && count == 3'd0) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      blk     <= 3'd0;
      tok_idx <= '0;
      blk_sel <= 3'd0;
      s2_vld  <= 1'b0;
      s2_dis  <= 1'b0;
      s2_tok  <= '0;
      s2_blk  <= 3'd0;
      s3_vld  <= 1'b0;
      s3_dis  <= 1'b0;
      s3_tok  <= '0;
      s3_blk  <= 3'd0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
    end else begin
      state   <= state_nxt;
      blk     <= blk_nxt;
      tok_idx <= tok_idx_nxt;
      // Block select is presented alongside the slot in S2 and held otherwise.
      if (issue || prime_slot) blk_sel <= blk;
      if (abort) begin
        s2_vld <= 1'b0;
        s3_vld <= 1'b0;
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
        count  <= 3'd0;
      end else begin
        s2_vld <= issue || prime_slot;
        s2_dis <= prime_slot;
        s2_tok <= tok_idx[AW-1:0];
        s2_blk <= blk;
        s3_vld <= s2_vld;
        s3_dis <= s2_dis;
        s3_tok <= s2_tok;
        s3_blk <= s2_blk;
        if (push) begin
          mem[wr_ptr] <= '{q: qkv_q, k: qkv_k, v: qkv_v, tok: s3_tok, blk: s3_blk};
          wr_ptr      <= wr_ptr + 2'd1;
        end
        if (pop) rd_ptr <= rd_ptr + 2'd1;
        count <= count + {2'b00, push} - {2'b00, pop};
      end
    end
  end

`ifdef QKV_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall <= 16'd0;
    end else if (state == S_IDLE && start && !abort) begin
      perf_stall <= 16'd0;
    end else if (state == S_RUN && !credit_ok && perf_stall != 16'hFFFF) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

  // Head fields are gated so an empty FIFO presents all-zero outputs.
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    tok_rd_en    = issue;
    tok_rd_addr  = issue ? tok_idx[AW-1:0] : '0;
    qkv_in_valid = s2_vld;
    qkv_data_in  = s2_real ? tok_rd_data : '0;
    qkv_blk_sel  = blk_sel;
    out_valid    = (count != 3'd0);
    out_q        = out_valid ? mem[rd_ptr].q   : '0;
    out_k        = out_valid ? mem[rd_ptr].k   : '0;
    out_v        = out_valid ? mem[rd_ptr].v   : '0;
    out_tok      = out_valid ? mem[rd_ptr].tok : '0;
    out_blk      = out_valid ? mem[rd_ptr].blk : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_qkv_seq_ctrl.sv
// tb_qkv_seq_ctrl: random tokens/weights, behavioural token buffer and ROM-based engine, scoreboard of
// block-major results. Define QKV_SEQ_PERF_EN to also check perf_stall.
`default_nettype none

module tb_qkv_seq_ctrl;
  localparam int DW = 16, AW = 5, TOKENS = 30, BLOCKS = 6, TOTAL = TOKENS * BLOCKS;

  logic clk, rst_n, start, abort, busy, done, tok_rd_en, qkv_in_valid, qkv_out_valid, out_valid, out_ready;
  logic [AW-1:0] tok_rd_addr, out_tok;
  logic [DW-1:0] tok_rd_data, qkv_data_in, qkv_q, qkv_k, qkv_v, out_q, out_k, out_v;
  logic [2:0]    qkv_blk_sel, out_blk;
`ifdef QKV_SEQ_PERF_EN
  logic [15:0]   perf_stall;
`endif

  int checks = 0, failures = 0;

  qkv_seq_ctrl #(.DW(DW), .AW(AW), .TOKENS(TOKENS), .BLOCKS(BLOCKS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .tok_rd_en(tok_rd_en), .tok_rd_addr(tok_rd_addr), .tok_rd_data(tok_rd_data),
    .qkv_data_in(qkv_data_in), .qkv_in_valid(qkv_in_valid), .qkv_blk_sel(qkv_blk_sel),
    .qkv_q(qkv_q), .qkv_k(qkv_k), .qkv_v(qkv_v), .qkv_out_valid(qkv_out_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_k(out_k), .out_v(out_v),
    .out_tok(out_tok), .out_blk(out_blk)
`ifdef QKV_SEQ_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Token buffer and engine models
  logic [DW-1:0] tokbuf [32];
  logic [DW-1:0] wq_rom [8], wk_rom [8], wv_rom [8];
  logic [DW-1:0] wq_r, wk_r, wv_r;

  function automatic logic [DW-1:0] bproj(input logic [DW-1:0] x, input logic [DW-1:0] w);
    logic [DW-1:0] r, rot;
    for (int j = 0; j < DW; j++) begin
      rot  = (j == 0) ? w : ((w << j) | (w >> (DW - j)));
      r[j] = ($countones(~(x ^ rot)) >= DW / 2);
    end
    return r;
  endfunction

  initial begin
    tok_rd_data = '0; qkv_q = '0; qkv_k = '0; qkv_v = '0; qkv_out_valid = 1'b0;
    wq_r = '0; wk_r = '0; wv_r = '0;
  end

  always @(posedge clk) if (tok_rd_en) tok_rd_data <= tokbuf[tok_rd_addr];

  // Synchronous ROM: the result of this cycle uses the weights latched by the previous valid cycle.
  always @(posedge clk) begin
    qkv_out_valid <= qkv_in_valid;
    if (qkv_in_valid) begin
      qkv_q <= bproj(qkv_data_in, wq_r);
      qkv_k <= bproj(qkv_data_in, wk_r);
      qkv_v <= bproj(qkv_data_in, wv_r);
      wq_r  <= wq_rom[qkv_blk_sel];
      wk_r  <= wk_rom[qkv_blk_sel];
      wv_r  <= wv_rom[qkv_blk_sel];
    end
  end

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) tokbuf[i] = DW'($urandom);
    for (int b = 0; b < 8; b++) begin
      wq_rom[b] = DW'($urandom); wk_rom[b] = DW'($urandom); wv_rom[b] = DW'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy, done, tok_rd_en, tok_rd_addr, qkv_data_in, qkv_in_valid, qkv_blk_sel, out_valid,
           out_q, out_k, out_v, out_tok, out_blk} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: busy=%b out_valid=%b tok_rd_en=%b qkv_in_valid=%b, required all zero",
                 busy, out_valid, tok_rd_en, qkv_in_valid);
      end
      if (i == 0) begin rst_n = 1'b1; @(negedge clk); end
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for cycles 60..79. poke: start pulses mid-run.
  task automatic run_and_check(input int mode, input bit poke, output int stalls);
    int issued, popped, dones, lastpop, firstpop, outst, prime_blk, cyc;
    bit in_prime, chk_prime, nxt_prime, finished, in_run;
    logic [DW-1:0] hq; logic [AW-1:0] ht; logic [2:0] hb;
    logic [DW-1:0] xq, xk, xv; int eb, et;
    stalls = 0; issued = 0; popped = 0; dones = 0; lastpop = -1; firstpop = -1;
    finished = 1'b0; in_prime = 1'b1; chk_prime = 1'b0; prime_blk = 0;
    hq = '0; ht = '0; hb = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (cyc = 1; cyc < 3000 && !finished; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(cyc >= 60 && cyc < 80);
      endcase
      start = poke && (cyc % 37 == 0);
      #1;
      outst  = issued - popped;
      in_run = busy && !in_prime && issued < TOTAL;
      checks++;
      if (outst > 4) begin
        failures++; $display("FAIL credit_bound cyc=%0d: outstanding=%0d, required <=4", cyc, outst);
      end
      checks++;
      if (in_run ? (tok_rd_en !== (outst < 4)) : (tok_rd_en !== 1'b0)) begin
        failures++;
        $display("FAIL issue_rate cyc=%0d: tok_rd_en=%b outstanding=%0d in_run=%0d", cyc, tok_rd_en, outst, in_run);
      end
      if (in_run && !tok_rd_en) stalls++;
      if (chk_prime) begin
        checks++;
        if (qkv_in_valid !== 1'b1 || qkv_data_in !== '0 || qkv_blk_sel !== 3'(prime_blk)) begin
          failures++;
          $display("FAIL prime_slot cyc=%0d: valid=%b data=%h sel=%0d, required 1/0000/%0d",
                   cyc, qkv_in_valid, qkv_data_in, qkv_blk_sel, prime_blk);
        end
      end
      chk_prime = in_prime;
      nxt_prime = 1'b0;
      if (tok_rd_en) begin
        checks++;
        if (tok_rd_addr !== AW'(issued % TOKENS)) begin
          failures++;
          $display("FAIL rd_addr cyc=%0d: got %0d, required %0d", cyc, tok_rd_addr, issued % TOKENS);
        end
        issued++;
        if (issued % TOKENS == 0 && issued < TOTAL) begin
          nxt_prime = 1'b1; prime_blk = issued / TOKENS;
        end
      end
      if (!chk_prime || nxt_prime) chk_prime = chk_prime; // prime check follows the prime cycle
      in_prime = nxt_prime;
      if (mode == 2 && cyc >= 60 && cyc < 80) begin
        if (cyc == 60) begin hq = out_q; ht = out_tok; hb = out_blk; end
        checks++;
        if (out_valid !== 1'b1 || out_q !== hq || out_tok !== ht || out_blk !== hb) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d: valid=%b tok=%0d blk=%0d, required 1 tok=%0d blk=%0d",
                   cyc, out_valid, out_tok, out_blk, ht, hb);
        end
        if (cyc == 79) begin
          checks++;
          if (outst != 4) begin
            failures++; $display("FAIL stall_fill: outstanding=%0d, required 4", outst);
          end
        end
      end
      if (out_valid && out_ready) begin
        eb = popped / TOKENS; et = popped % TOKENS;
        xq = bproj(tokbuf[et], wq_rom[eb]); xk = bproj(tokbuf[et], wk_rom[eb]); xv = bproj(tokbuf[et], wv_rom[eb]);
        checks++;
        if (popped >= TOTAL || out_tok !== AW'(et) || out_blk !== 3'(eb) ||
            out_q !== xq || out_k !== xk || out_v !== xv) begin
          failures++;
          $display("FAIL result #%0d: tok=%0d blk=%0d q=%h k=%h v=%h, required tok=%0d blk=%0d q=%h k=%h v=%h",
                   popped, out_tok, out_blk, out_q, out_k, out_v, et, eb, xq, xk, xv);
        end
        if (firstpop < 0) firstpop = cyc;
        popped++; lastpop = cyc;
      end
      if (done) begin dones++; finished = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (!finished || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_end mode=%0d: finished=%0d done=%b busy=%b, required 1/0/0", mode, finished, done, busy);
    end
    checks++;
    if (dones != 1 || popped != TOTAL || issued != TOTAL) begin
      failures++;
      $display("FAIL run_count mode=%0d: dones=%0d popped=%0d issued=%0d, required 1/%0d/%0d",
               mode, dones, popped, issued, TOTAL, TOTAL);
    end
    if (mode == 0) begin
      checks++;
      if (firstpop != 5 || lastpop != TOTAL + BLOCKS + 3) begin
        failures++;
        $display("FAIL run_timing: first=%0d last=%0d, required 5/%0d", firstpop, lastpop, TOTAL + BLOCKS + 3);
      end
    end
  endtask

  task automatic test_abort();
    randomize_mem();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL abort_pre_done cyc=%0d: done=%b, required 0", i, done); end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || tok_rd_en !== 1'b0 || (i == 0 && qkv_in_valid !== 1'b0)) begin
        failures++;
        $display("FAIL abort_flush +%0d: busy=%b done=%b out_valid=%b rd=%b in_valid=%b, required all 0",
                 i + 1, busy, done, out_valid, tok_rd_en, qkv_in_valid);
      end
      if (i == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    randomize_mem();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_mid_busy: busy=%b, required 1", busy); end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if ({busy, done, tok_rd_en, tok_rd_addr, qkv_data_in, qkv_in_valid, qkv_blk_sel, out_valid,
         out_q, out_k, out_v, out_tok, out_blk} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: busy=%b out_valid=%b rd=%b in_valid=%b sel=%0d, required all zero",
               busy, out_valid, tok_rd_en, qkv_in_valid, qkv_blk_sel);
    end
    @(negedge clk);
  endtask

  initial begin
    int st;
    int stall3;
    test_reset();
    randomize_mem(); run_and_check(0, 1'b0, st);       // full run, ready high
    checks++;
    if (st != 0) begin failures++; $display("FAIL no_stall_ready_high: stalls=%0d, required 0", st); end
    randomize_mem(); run_and_check(2, 1'b0, stall3);   // 20-cycle back-pressure window
`ifdef QKV_SEQ_PERF_EN
    checks++;
    if (perf_stall !== 16'(stall3)) begin
      failures++; $display("FAIL perf_stall: got %0d, required %0d", perf_stall, stall3);
    end
`endif
    randomize_mem(); run_and_check(1, 1'b0, st);       // random ready
    test_abort();
    run_and_check(0, 1'b0, st);                        // restart after abort
    randomize_mem(); run_and_check(1, 1'b1, st);       // start pulses during run
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
